// File: rtl/ps2_key_fifo_if.sv
// ps2_key_fifo_if: the byte stream from the ps2 receiver, the CPU-side pop and
// flush strobes, and the key FIFO status.
//   master : the receiver/bus side. It drives ps2_data, ps2_ready, rd and clr,
//            and observes key, key_valid, count and overflow.
//   slave  : ps2_key_fifo.
interface ps2_key_fifo_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic [7:0]            ps2_data;
    logic                  ps2_ready;
    logic                  rd;
    logic                  clr;
    logic [9:0]            key;
    logic                  key_valid;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output ps2_data, ps2_ready, rd, clr,
        input  key, key_valid, count, overflow
    );

    modport slave (
        input  ps2_data, ps2_ready, rd, clr,
        output key, key_valid, count, overflow
    );
endinterface

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: decodes PS/2 set-2 bytes (E0/F0/E1 prefixes) into 10-bit key
// events {ext, brk, code} and buffers them in a show-ahead circular FIFO.
//   clk  : system clock
//   RSTN : asynchronous active-low reset
//   bus  : ps2_key_fifo_if.slave (ps2_data/ps2_ready in, rd/clr in,
//          key/key_valid/count/overflow out)
//
// state | meaning
// IDLE  | no prefix pending
// E0    | extended prefix seen
// F0    | break prefix seen
// E0F0  | extended break prefix seen
// SKIP  | swallowing the remaining bytes of the Pause (E1) sequence
module ps2_key_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 2_000_000
) (
    input logic          clk,
    input logic          RSTN,
    ps2_key_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} state_t;

    state_t          state, state_nx, cur;
    logic [2:0]      skip_cnt, skip_nx;
    logic [TW-1:0]   to_cnt;
    logic            expired;
    logic            ev_push;
    logic [9:0]      ev_data;

    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  full, empty, do_pop, do_push;

    function automatic logic is_response(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    assign expired = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        skip_nx  = expired ? 3'd0 : skip_cnt;
        ev_push  = 1'b0;
        ev_data  = 10'h000;
        // An expiring sequence is abandoned first so a byte in that cycle
        // is decoded as if the FSM were already idle.
        cur      = expired ? S_IDLE : state;
        if (expired)
            state_nx = S_IDLE;
        if (bus.ps2_ready) begin
            if (cur == S_SKIP) begin
                skip_nx = skip_cnt - 3'd1;
                if (skip_cnt <= 3'd1) begin
                    state_nx = S_IDLE;
                    skip_nx  = 3'd0;
                    ev_push  = (skip_cnt == 3'd1);
                    ev_data  = 10'h277;
                end
            end else if (bus.ps2_data == 8'hE1) begin
                state_nx = S_SKIP;
                skip_nx  = 3'd7;
            end else begin
                case (cur)
                    S_IDLE: begin
                        if (bus.ps2_data == 8'hE0)
                            state_nx = S_E0;
                        else if (bus.ps2_data == 8'hF0)
                            state_nx = S_F0;
                        else if (!is_response(bus.ps2_data)) begin
                            ev_push = 1'b1;
                            ev_data = {2'b00, bus.ps2_data};
                        end
                    end
                    S_E0, S_F0, S_E0F0: begin
                        if (bus.ps2_data == 8'hE0)
                            state_nx = S_E0;
                        else if (bus.ps2_data == 8'hF0)
                            state_nx = (cur == S_F0) ? S_F0 : S_E0F0;
                        else begin
                            state_nx = S_IDLE;
                            ev_push  = 1'b1;
                            ev_data  = {cur != S_F0, cur != S_E0, bus.ps2_data};
                        end
                    end
                    default: state_nx = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
            to_cnt   <= '0;
        end else if (bus.clr) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
            if (bus.ps2_ready || state == S_IDLE || expired)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);
        end
    end

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = bus.rd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = ev_push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !bus.clr)
            mem[wptr] <= ev_data;
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wptr <= wptr + DEPTH_LOG2'(1);
            if (do_pop)
                rptr <= rptr + DEPTH_LOG2'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
            if (ev_push && !do_push)
                overflow <= 1'b1;
        end
    end

    assign bus.key       = empty ? 10'h000 : mem[rptr];
    assign bus.key_valid = !empty;
    assign bus.count     = count;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;
    localparam int DL2 = 3;
    localparam int TO  = 40;

    logic clk;
    logic RSTN;
    int   checks;
    int   errors;
    logic [9:0] q[$];

    ps2_key_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    ps2_key_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT(TO)) dut (
        .clk (clk),
        .RSTN(RSTN),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic [9:0] k;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ev, input logic [9:0] k);
        @(negedge clk);
        bus.ps2_data  = b;
        bus.ps2_ready = 1'b1;
        @(negedge clk);
        bus.ps2_ready = 1'b0;
        if (ev && q.size() < 8)
            q.push_back(k);
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        if (q.size() > 0)
            void'(q.pop_front());
    endtask

    // byte and pop in the same cycle; the model pops first, then pushes
    task automatic send_byte_rd(input logic [7:0] b, input logic [9:0] k);
        @(negedge clk);
        bus.ps2_data  = b;
        bus.ps2_ready = 1'b1;
        bus.rd        = 1'b1;
        @(negedge clk);
        bus.ps2_ready = 1'b0;
        bus.rd        = 1'b0;
        if (q.size() > 0)
            void'(q.pop_front());
        q.push_back(k);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        q.delete();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!bus.key_valid)
                break;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: unexpected key %0h, expected none", name, bus.key);
                break;
            end
            check(name, 32'(bus.key), 32'(q[0]));
            pulse_rd();
        end
        check({name, " empty"}, 32'(q.size()), 32'd0);
        check({name, " count"}, 32'(bus.count), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.ps2_data  = 8'h00;
        bus.ps2_ready = 1'b0;
        bus.rd        = 1'b0;
        bus.clr       = 1'b0;

        vecs[0]  = '{8'h1C, 1'b1, 10'h01C};
        vecs[1]  = '{8'hF0, 1'b0, 10'h000};
        vecs[2]  = '{8'h1C, 1'b1, 10'h11C};
        vecs[3]  = '{8'hE0, 1'b0, 10'h000};
        vecs[4]  = '{8'h75, 1'b1, 10'h275};
        vecs[5]  = '{8'hFA, 1'b0, 10'h000};
        vecs[6]  = '{8'hAA, 1'b0, 10'h000};
        vecs[7]  = '{8'hE0, 1'b0, 10'h000};
        vecs[8]  = '{8'hF0, 1'b0, 10'h000};
        vecs[9]  = '{8'h75, 1'b1, 10'h375};
        vecs[10] = '{8'hE1, 1'b0, 10'h000};
        vecs[11] = '{8'h14, 1'b0, 10'h000};
        vecs[12] = '{8'h77, 1'b0, 10'h000};
        vecs[13] = '{8'hE1, 1'b0, 10'h000};
        vecs[14] = '{8'hF0, 1'b0, 10'h000};
        vecs[15] = '{8'h14, 1'b0, 10'h000};
        vecs[16] = '{8'hF0, 1'b0, 10'h000};
        vecs[17] = '{8'h77, 1'b1, 10'h277};
        vecs[18] = '{8'h1C, 1'b1, 10'h01C};

        RSTN = 1'b0;
        repeat (3) @(negedge clk);
        check("reset count", 32'(bus.count), 32'd0);
        check("reset key_valid", 32'(bus.key_valid), 32'd0);
        check("reset key", 32'(bus.key), 32'h000);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        RSTN = 1'b1;

        // make/break
        send_byte(8'h1C, 1'b1, 10'h01C);
        send_byte(8'hF0, 1'b0, 10'h000);
        send_byte(8'h1C, 1'b1, 10'h11C);
        check("mb count", 32'(bus.count), 32'd2);
        check("mb head", 32'(bus.key), 32'h01C);
        pulse_rd();
        check("mb head after rd", 32'(bus.key), 32'h11C);
        pulse_rd();
        check("mb empty", 32'(bus.key_valid), 32'd0);

        // table: make/break, extended, filtered responses, pause
        for (int i = 0; i < 19; i++) begin
            send_byte(vecs[i].b, vecs[i].ev, vecs[i].k);
            check($sformatf("vec%0d count", i), 32'(bus.count), 32'(q.size()));
            check($sformatf("vec%0d head", i), 32'(bus.key),
                  (q.size() > 0) ? 32'(q[0]) : 32'h000);
        end
        drain("table drain");

        // overflow: 9 makes, last is dropped
        for (int i = 0; i < 9; i++)
            send_byte(8'h15 + 8'(i), 1'b1, 10'h015 + 10'(i));
        check("ovf count", 32'(bus.count), 32'd8);
        check("ovf flag", 32'(bus.overflow), 32'd1);
        check("ovf head", 32'(bus.key), 32'h015);
        check("ovf last model", 32'(q[7]), 32'h01C);
        drain("ovf drain");
        check("ovf sticky", 32'(bus.overflow), 32'd1);
        pulse_clr();
        check("clr overflow", 32'(bus.overflow), 32'd0);
        check("clr count", 32'(bus.count), 32'd0);

        for (int i = 0; i < 8; i++)
            send_byte(8'h20 + 8'(i), 1'b1, 10'h020 + 10'(i));
        send_byte_rd(8'h28, 10'h028);
        check("full rd+push count", 32'(bus.count), 32'd8);
        check("full rd+push overflow", 32'(bus.overflow), 32'd0);
        check("full rd+push head", 32'(bus.key), 32'h021);
        pulse_clr();
        check("clr2 count", 32'(bus.count), 32'd0);
        check("clr2 key_valid", 32'(bus.key_valid), 32'd0);
        check("clr2 key", 32'(bus.key), 32'h000);

        // short gap keeps the prefix, long gap abandons it
        send_byte(8'hE0, 1'b0, 10'h000);
        repeat (3) @(negedge clk);
        send_byte(8'h1C, 1'b1, 10'h21C);
        send_byte(8'hE0, 1'b0, 10'h000);
        repeat (TO) @(negedge clk);
        send_byte(8'h1C, 1'b1, 10'h01C);
        drain("timeout drain");

        // pointer wrap with simultaneous push/pop
        for (int i = 0; i < 3; i++)
            send_byte(8'h30 + 8'(i), 1'b1, 10'h030 + 10'(i));
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap%0d head", i), 32'(bus.key), 32'(q[0]));
            send_byte_rd(8'h40 + 8'(i), 10'h040 + 10'(i));
            check($sformatf("wrap%0d count", i), 32'(bus.count), 32'd3);
        end
        drain("wrap drain");

        // reset in E0F0 with 3 entries stored
        for (int i = 0; i < 3; i++)
            send_byte(8'h50 + 8'(i), 1'b1, 10'h050 + 10'(i));
        send_byte(8'hE0, 1'b0, 10'h000);
        send_byte(8'hF0, 1'b0, 10'h000);
        @(negedge clk);
        RSTN = 1'b0;
        #1;
        check("async rst key_valid", 32'(bus.key_valid), 32'd0);
        check("async rst count", 32'(bus.count), 32'd0);
        q.delete();
        @(negedge clk);
        RSTN = 1'b1;
        send_byte(8'h1C, 1'b1, 10'h01C);
        check("post rst key", 32'(bus.key), 32'h01C);
        drain("post rst drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Decodes the raw PS/2 set-2 byte stream from the `ps2` receiver into key events, combining the E0 (extended), F0 (break) and E1 (pause) prefixes. Buffers the events in a small FIFO, so the CPU does not lose keystrokes between polls. Sits between `ps2` (`data_out`/`ready`) and `MIO_BUS` (`ps2kb_key`). Each event is a 10-bit word {ext, brk, code[7:0]}, matching the existing 10-bit keyboard bus width.

## Interface
Parameters:
- `DEPTH_LOG2`, 3, log2 of FIFO depth (DEPTH = 8 entries).
- `TIMEOUT`, 2_000_000, cycles of byte silence after which a partial prefix sequence is abandoned (20 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock (clk_100mhz domain). The block has one clock.
- `RSTN`  in  1  reset, asynchronous, active-low.
- `ps2_data`  in  8  received byte from `ps2`. Valid only while `ps2_ready` is high.
- `ps2_ready`  in  1  one-cycle strobe: `ps2_data` holds a new byte.
- `rd`  in  1  one-cycle pop strobe from the bus (CPU read of the key register).
- `clr`  in  1  synchronous flush: empties the FIFO, clears `overflow`, returns the FSM to IDLE.
- `key`  out  10  FIFO head, show-ahead {ext, brk, code}. Reads 10'h000 when empty.
- `key_valid`  out  1  FIFO non-empty.
- `count`  out  DEPTH_LOG2+1  number of stored events, 0..DEPTH.
- `overflow`  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- Reset (`RSTN`=0, asynchronous):
  - pointers and `count` = 0, `key_valid` = 0, `key` = 0, `overflow` = 0;
  - FSM = IDLE, skip counter = 0, timeout counter = 0.
- Decoder FSM states: IDLE, E0, F0, E0F0, SKIP. It advances only on `ps2_ready`=1.
- IDLE:
  - E0 -> E0; F0 -> F0; E1 -> SKIP (skip counter = 7);
  - 00, AA, EE, FA, FC, FE, FF -> discarded (keyboard responses), stay IDLE;
  - any other byte c -> push {0,0,c}, stay IDLE.
- E0:
  - F0 -> E0F0; E0 -> E0;
  - other c -> push {1,0,c}, go to IDLE.
- F0:
  - other c -> push {0,1,c}, go to IDLE;
  - F0 -> F0; E0 -> E0 (partial sequence dropped).
- E0F0:
  - other c -> push {1,1,c}, go to IDLE;
  - F0 -> E0F0; E0 -> E0.
- E1 in any non-SKIP state -> SKIP with skip counter = 7. The partial sequence is dropped.
- SKIP:
  - each byte decrements the skip counter;
  - the byte that brings it from 1 to 0 pushes 10'h277 (Pause, ext make) and goes to IDLE;
  - no bytes are decoded while in SKIP.
- Timeout:
  - the counter runs whenever FSM != IDLE and resets on every `ps2_ready`;
  - reaching TIMEOUT-1 forces IDLE without a push.
- FIFO:
  - circular, DEPTH entries, read/write pointers wrap modulo DEPTH;
  - `count` is kept explicitly.
- Push while full:
  - event dropped, `overflow` <= 1;
  - exception: if `rd` is high in the same cycle, pop and push both occur, `count` is unchanged and there is no overflow.
- Pop (`rd`=1) while empty: ignored. If a push occurs in the same cycle, the push still occurs.
- `clr` has priority over push and pop in the same cycle. It also clears the skip and timeout counters.
- `overflow` is cleared only by `clr` or reset.

## Timing
- Byte to event latency: a final byte strobed in cycle N is written at the end of cycle N.
  - `key_valid` = 1 and `key` are valid in cycle N+1.
  - If the FIFO was empty, this entry is the head.
- Pop: with `rd` in cycle N, `key`, `count` and `key_valid` update in cycle N+1.
- `key` is combinational from the FIFO head (registered storage plus read mux). There is no extra latency.
- `rd` and `ps2_ready` must be single-cycle pulses. A level held for k cycles counts as k events.
- Timeout expiry is checked every cycle. A byte arriving in the expiry cycle is decoded from IDLE.
- Deassertion of `RSTN` takes effect at the next `clk` edge. No output glitches besides the asynchronous clear.

## Test plan
- Make/break: bytes 1C, F0, 1C -> two events 10'h01C then 10'h11C. `count`=2, and `key` reads 01C before pop, 11C after one `rd`.
- Extended: E0 75, E0 F0 75 -> events 10'h275 then 10'h375. Filtered responses FA and AA in between yield no events.
- Pause: E1 14 77 E1 F0 14 F0 77 -> exactly one event 10'h277, FSM in IDLE afterwards.
- Overflow: push 9 makes (codes 15..1D) with no reads -> `count`=8, `overflow`=1, head 015, last entry 1C.
  - Then `rd` and push in the same cycle while full -> `count` stays 8.
  - Then `clr` -> `count`=0, `overflow`=0.
- Timeout/wrap:
  - E0, then TIMEOUT cycles of silence, then 1C -> event 10'h01C (not 21C).
  - Cycle 20 push/pop pairs -> pointers wrap and order is preserved.
- Reset mid-operation: assert `RSTN`=0 in state E0F0 with 3 entries stored -> `key_valid`=0, `count`=0 immediately.
  - After release, F0-less byte 1C -> 10'h01C.
